// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer. The mainfsm imports this
// package as well, so that both sides agree on the state encodings used by
// the stall handshake.
package div_sequencer_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide step (combinational).
//   rem   : partial remainder going into the step
//   q     : shift register; dividend bits in the top, quotient bits in the bottom
//   dvs   : divisor magnitude
//   rem_n : partial remainder after the step
//   q_n   : shift register after the step, with the new quotient bit in bit 0
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] q_n
);

  // The bit shifted out of rem is kept in the compare. Without it, an
  // unsigned divisor above 2^(WIDTH-1) could give a wrong quotient bit.
  // The subtraction result is always less than dvs, so it fits in WIDTH bits.
  logic [WIDTH:0] trial;

  always_comb begin
    trial = {rem, q[WIDTH-1]};
    q_n   = {q[WIDTH-2:0], 1'b0};
    rem_n = trial[WIDTH-1:0];
    if (trial >= {1'b0, dvs}) begin
      rem_n  = trial[WIDTH-1:0] - dvs;
      q_n[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle SDIV/UDIV sequencer: radix-2 restoring divide, one quotient bit per cycle.
// Ports:
//   clk, reset (async, active-low)
//   start, abort, signed_op, dividend, divisor : request from decode/mainfsm
//   busy, done                                 : handshake back to mainfsm
//   quotient, remainder, div_by_zero, flag_n, flag_z : results for the result mux
//
// state  | meaning
// IDLE   | waiting for start; operands are latched when start is accepted
// PREP   | take magnitudes, record the result signs, load the counter
// ITER   | one restoring step per cycle, WIDTH cycles
// FIX    | apply the signs and drive quotient/remainder/flags
// DONE   | one-cycle done pulse, then IDLE
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter  int WIDTH = DIV_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             flag_n,
  output logic             flag_z
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_reg, dvs_reg, rem_reg;
  logic [WIDTH-1:0] step_q, step_rem;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic             is_signed, sign_q, sign_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem_reg),
    .q     (q_reg),
    .dvs   (dvs_reg),
    .rem_n (step_rem),
    .q_n   (step_q)
  );

  // sign_q and sign_r are only ever set for signed operations.
  // INT_MIN / -1 wraps naturally: the magnitude quotient 0x80000000 is kept as it is.
  assign fix_q = sign_q ? -q_reg : q_reg;
  assign fix_r = sign_r ? -rem_reg : rem_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_PREP;
      S_PREP: begin
        busy     = 1'b1;
        state_nx = (dvs_reg == '0) ? S_DONE : S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = S_FIX;
      end
      S_FIX: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      is_signed   <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      flag_n      <= 1'b0;
      flag_z      <= 1'b0;
    end else if (!abort) begin
      case (state)
        S_IDLE: if (start) begin
          q_reg       <= dividend;
          dvs_reg     <= divisor;
          is_signed   <= signed_op;
          div_by_zero <= 1'b0;
          flag_n      <= 1'b0;
          flag_z      <= 1'b0;
        end
        S_PREP: begin
          sign_q  <= is_signed & (q_reg[WIDTH-1] ^ dvs_reg[WIDTH-1]);
          sign_r  <= is_signed & q_reg[WIDTH-1];
          if (is_signed && q_reg[WIDTH-1])   q_reg   <= -q_reg;
          if (is_signed && dvs_reg[WIDTH-1]) dvs_reg <= -dvs_reg;
          rem_reg <= '0;
          cnt     <= CNT_W'(WIDTH - 1);
          // The divide-by-zero result is taken from the raw latched dividend.
          if (dvs_reg == '0) begin
            quotient    <= '0;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
            flag_z      <= 1'b1;
            flag_n      <= 1'b0;
          end
        end
        S_ITER: begin
          rem_reg <= step_rem;
          q_reg   <= step_q;
          cnt     <= cnt - 1'b1;
        end
        S_FIX: begin
          quotient  <= fix_q;
          remainder <= fix_r;
          flag_n    <= fix_q[WIDTH-1];
          flag_z    <= (fix_q == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero, flag_n, flag_z;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int passed = 0;

  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .flag_n(flag_n), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  // Present a request for one edge; returns #1 after the accepting edge E.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after E until done is seen (lat = -1 on timeout).
  // If pulse_at > 0, a competing start is pulsed for one edge at that count.
  task automatic wait_done(input int pulse_at, output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (pulse_at > 0 && n == pulse_at) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5; signed_op = 1'b0;
      end else if (pulse_at > 0 && n == pulse_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if ({busy, done, div_by_zero, flag_n, flag_z} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, div_by_zero, flag_n, flag_z}); else passed++;
    total++; if ({quotient, remainder} !== 64'd0)
      $display("FAIL reset_data: got q=%h r=%h want 0/0", quotient, remainder); else passed++;
    #2 reset = 1'b1;
  endtask

  task automatic test_udiv();
    int lat;
    issue(32'd100, 32'd7, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL udiv_busy: got %b want 1", busy); else passed++;
    wait_done(0, lat);
    total++; if (lat !== W + 2) $display("FAIL udiv_latency: got %0d want %0d", lat, W + 2); else passed++;
    total++; if (quotient !== 32'd14) $display("FAIL udiv_q: got %h want %h", quotient, 32'd14); else passed++;
    total++; if (remainder !== 32'd2) $display("FAIL udiv_r: got %h want %h", remainder, 32'd2); else passed++;
    total++; if ({flag_n, flag_z, div_by_zero, busy} !== 4'b0000)
      $display("FAIL udiv_flags: got %b want 0000", {flag_n, flag_z, div_by_zero, busy}); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done); else passed++;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    wait_done(0, lat);
    total++; if ({quotient, remainder} !== {32'd1, 32'd1})
      $display("FAIL udiv_big: got q=%h r=%h want 1/1", quotient, remainder); else passed++;
  endtask

  task automatic test_sdiv();
    int lat;
    issue(-32'sd100, 32'd7, 1'b1);
    wait_done(0, lat);
    total++; if (quotient !== 32'hFFFF_FFF2) $display("FAIL sdiv_q: got %h want FFFFFFF2", quotient); else passed++;
    total++; if (remainder !== 32'hFFFF_FFFE) $display("FAIL sdiv_r: got %h want FFFFFFFE", remainder); else passed++;
    total++; if ({flag_n, flag_z} !== 2'b10) $display("FAIL sdiv_flags: got %b want 10", {flag_n, flag_z}); else passed++;
    issue(32'd100, -32'sd7, 1'b1);
    wait_done(0, lat);
    total++; if ({quotient, remainder} !== {32'hFFFF_FFF2, 32'd2})
      $display("FAIL sdiv_pos_neg: got q=%h r=%h want FFFFFFF2/2", quotient, remainder); else passed++;
    issue(-32'sd100, -32'sd7, 1'b1);
    wait_done(0, lat);
    total++; if ({quotient, remainder, flag_n} !== {32'd14, 32'hFFFF_FFFE, 1'b0})
      $display("FAIL sdiv_neg_neg: got q=%h r=%h n=%b want E/FFFFFFFE/0", quotient, remainder, flag_n); else passed++;
  endtask

  task automatic test_div_zero();
    int lat;
    issue(32'd5, 32'd0, 1'b0);
    wait_done(0, lat);
    total++; if (lat !== 1) $display("FAIL dz_latency: got %0d want 1", lat); else passed++;
    total++; if ({quotient, remainder} !== {32'd0, 32'd5})
      $display("FAIL dz_result: got q=%h r=%h want 0/5", quotient, remainder); else passed++;
    total++; if ({div_by_zero, flag_z, flag_n} !== 3'b110)
      $display("FAIL dz_flags: got %b want 110", {div_by_zero, flag_z, flag_n}); else passed++;
    issue(32'd100, 32'd7, 1'b0);
    total++; if ({div_by_zero, flag_z} !== 2'b00)
      $display("FAIL dz_clear: got %b want 00", {div_by_zero, flag_z}); else passed++;
    wait_done(0, lat);
  endtask

  task automatic test_overflow();
    int lat;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(0, lat);
    total++; if ({quotient, remainder} !== {32'h8000_0000, 32'd0})
      $display("FAIL ovf_result: got q=%h r=%h want 80000000/0", quotient, remainder); else passed++;
    total++; if ({flag_n, div_by_zero} !== 2'b10)
      $display("FAIL ovf_flags: got %b want 10", {flag_n, div_by_zero}); else passed++;
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    issue(32'd9, 32'd2, 1'b0);
    wait_done(0, lat);
    issue(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    total++; if ({busy, done} !== 2'b00) $display("FAIL abort_idle: got %b want 00", {busy, done}); else passed++;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    total++; if (seen !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", seen); else passed++;
    total++; if ({quotient, remainder} !== {32'd4, 32'd1})
      $display("FAIL abort_hold: got q=%h r=%h want 4/1", quotient, remainder); else passed++;
    #1 start = 1'b1; abort = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_wins: got busy=%b want 0", busy); else passed++;
    issue(32'd3, 32'd3, 1'b0);
    wait_done(0, lat);
    total++; if ({quotient, remainder} !== {32'd1, 32'd0})
      $display("FAIL abort_next: got q=%h r=%h want 1/0", quotient, remainder); else passed++;
  endtask

  task automatic test_busy_ignore();
    int lat;
    issue(32'd100, 32'd7, 1'b0);
    wait_done(3, lat);
    total++; if (lat !== W + 2) $display("FAIL busy_latency: got %0d want %0d", lat, W + 2); else passed++;
    total++; if ({quotient, remainder} !== {32'd14, 32'd2})
      $display("FAIL busy_ignore: got q=%h r=%h want E/2", quotient, remainder); else passed++;
    // start held during DONE must not be accepted
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL done_ignore: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_async_reset();
    int lat;
    issue(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    total++; if ({busy, done, div_by_zero, flag_n, flag_z} !== 5'b0)
      $display("FAIL areset_ctrl: got %b want 00000", {busy, done, div_by_zero, flag_n, flag_z}); else passed++;
    total++; if ({quotient, remainder} !== 64'd0)
      $display("FAIL areset_data: got q=%h r=%h want 0/0", quotient, remainder); else passed++;
    #2 reset = 1'b1;
    issue(32'd77, 32'd10, 1'b0);
    wait_done(0, lat);
    total++; if ({quotient, remainder} !== {32'd7, 32'd7})
      $display("FAIL areset_after: got q=%h r=%h want 7/7", quotient, remainder); else passed++;
  endtask

  initial begin
    test_reset();
    test_udiv();
    test_sdiv();
    test_div_zero();
    test_overflow();
    test_abort();
    test_busy_ignore();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
